// File: rtl/screen_sequencer_pkg.sv
// Shared constants for the screen sequencer: screen IDs, FSM state
// encodings and the default framebuffer size.
`ifndef DISP_ADDR_WIDTH
`define DISP_ADDR_WIDTH 17
`endif

package screen_pkg;

  // Screen IDs; also the bit index of each screen in the packed buses.
  localparam logic [1:0] SCR_MENU = 2'd0;
  localparam logic [1:0] SCR_GAME = 2'd1;
  localparam logic [1:0] SCR_WIN  = 2'd2;
  localparam logic [1:0] SCR_LOSE = 2'd3;

  // Sequencer FSM encodings.
  localparam logic [1:0] ST_CLEAR  = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;

  // 320x240 framebuffer.
  localparam int DEFAULT_FB_PIXELS = 76800;

endpackage

// File: rtl/screen_sequencer_if.sv
// Screen-side bus of the sequencer: packed per-screen write ports and done
// pulses in, per-screen resets and the shared framebuffer port out.
interface screen_sequencer_if #(
  parameter int ADDR_W = `DISP_ADDR_WIDTH
);
  logic [3:0]          scr_fb_we;
  logic [4*ADDR_W-1:0] scr_fb_addr;
  logic [4*32-1:0]     scr_fb_wdata;
  logic [3:0]          scr_done;
  logic                game_won;
  logic [3:0]          scr_rst_n;
  logic [1:0]          active_screen;
  logic                fb_we;
  logic [ADDR_W-1:0]   fb_addr;
  logic [31:0]         fb_wdata;

  // Screens plus framebuffer side (drives the screen inputs).
  modport master (
    output scr_fb_we, scr_fb_addr, scr_fb_wdata, scr_done, game_won,
    input  scr_rst_n, active_screen, fb_we, fb_addr, fb_wdata
  );

  // The sequencer itself.
  modport slave (
    input  scr_fb_we, scr_fb_addr, scr_fb_wdata, scr_done, game_won,
    output scr_rst_n, active_screen, fb_we, fb_addr, fb_wdata
  );
endinterface

// File: rtl/screen_sequencer_fb_clear_counter.sv
// Address generator for the framebuffer zero-fill sweep. Comes out of reset
// already sweeping; afterwards a sweep is launched by a one-cycle start.
module fb_clear_counter
  import screen_pkg::*;
#(
  parameter  int FB_PIXELS = DEFAULT_FB_PIXELS,
  localparam int CNT_W     = (FB_PIXELS > 1) ? $clog2(FB_PIXELS) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic [CNT_W-1:0] addr,
  output logic             busy,
  output logic             last
);

  logic [CNT_W-1:0] clr_cnt;
  logic             busy_q;

  assign addr = clr_cnt;
  assign busy = busy_q;
  // Compare explicitly; FB_PIXELS need not be a power of two.
  assign last = busy_q && (clr_cnt == CNT_W'(FB_PIXELS - 1));

  // Sweep 0..FB_PIXELS-1, one address per cycle, then park at 0 and go idle.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of the order the always blocks evaluate.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clr_cnt <= '0;
      busy_q  <= 1'b1;
    end else if (start) begin
      clr_cnt <= '0;
      busy_q  <= 1'b1;
    end else if (busy_q) begin
      if (last) begin
        clr_cnt <= '0;
        busy_q  <= 1'b0;
      end else begin
        clr_cnt <= clr_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/screen_sequencer.sv
// Top-level screen controller: owns the framebuffer write port, sequences
// MENU -> GAME -> WIN/LOSE -> MENU, zero-fills the framebuffer between
// screens and keeps every inactive screen in reset.
module screen_sequencer
  import screen_pkg::*;
#(
  parameter int FB_PIXELS = DEFAULT_FB_PIXELS,
  parameter int ADDR_W    = `DISP_ADDR_WIDTH
) (
  input logic               clk,
  input logic               reset_n,
  screen_sequencer_if.slave bus
);

  localparam int CNT_W = (FB_PIXELS > 1) ? $clog2(FB_PIXELS) : 1;

  logic [1:0]        state;
  logic [1:0]        target;
  logic [1:0]        active_q;
  logic [3:0]        scr_rst_q;
  logic              fb_we_q;
  logic [ADDR_W-1:0] fb_addr_q;
  logic [31:0]       fb_wdata_q;

  logic              clr_start;
  logic              clr_busy;
  logic              clr_last;
  logic [CNT_W-1:0]  clr_addr;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic              done_active;

  // Screen that follows the current one when it reports done.
  function automatic logic [1:0] next_screen(input logic [1:0] cur,
                                             input logic       won);
    case (cur)
      SCR_MENU: return SCR_GAME;
      SCR_GAME: return won ? SCR_WIN : SCR_LOSE;
      default:  return SCR_MENU;
    endcase
  endfunction

  fb_clear_counter #(.FB_PIXELS(FB_PIXELS)) u_clear (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (clr_start),
    .addr    (clr_addr),
    .busy    (clr_busy),
    .last    (clr_last)
  );

  // Select the active screen's write port and done bit; others are ignored.
  // NOTE: every output gets a value before any condition, so no latch forms.
  always_comb begin
    sel_we      = bus.scr_fb_we[active_q];
    sel_addr    = bus.scr_fb_addr[int'(active_q) * ADDR_W +: ADDR_W];
    sel_wdata   = bus.scr_fb_wdata[int'(active_q) * 32 +: 32];
    done_active = (state == ST_RUN) && bus.scr_done[active_q];
  end

  assign clr_start = done_active;

  // FSM plus registered framebuffer port, screen resets and active ID.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_CLEAR;
      target     <= SCR_MENU;
      active_q   <= SCR_MENU;
      scr_rst_q  <= 4'b0000;
      fb_we_q    <= 1'b0;
      fb_addr_q  <= '0;
      fb_wdata_q <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          fb_we_q    <= clr_busy;
          fb_addr_q  <= ADDR_W'(clr_addr);
          fb_wdata_q <= '0;
          scr_rst_q  <= 4'b0000;
          if (clr_last) state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          fb_we_q   <= 1'b0;
          scr_rst_q <= 4'b0001 << target;
          active_q  <= target;
          state     <= ST_RUN;
        end
        ST_RUN: begin
          if (done_active) begin
            // The write presented alongside done is dropped.
            fb_we_q   <= 1'b0;
            scr_rst_q <= 4'b0000;
            target    <= next_screen(active_q, bus.game_won);
            state     <= ST_CLEAR;
          end else begin
            fb_we_q    <= sel_we;
            fb_addr_q  <= sel_addr;
            fb_wdata_q <= sel_wdata;
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

  assign bus.active_screen = active_q;
  assign bus.scr_rst_n     = scr_rst_q;
  assign bus.fb_we         = fb_we_q;
  assign bus.fb_addr       = fb_addr_q;
  assign bus.fb_wdata      = fb_wdata_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// Directed bench for screen_sequencer with a 16-word framebuffer: bring-up
// clear, forwarding, outcome routing, ignored done pulses, dropped write on
// done and reset in the middle of a clear.
module tb_screen_sequencer;

  localparam int FBP = 16;
  localparam int AW  = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  screen_sequencer_if #(.ADDR_W(AW)) bus ();

  screen_sequencer #(.FB_PIXELS(FBP), .ADDR_W(AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_screen(input int i, input logic we,
                            input logic [AW-1:0] addr, input logic [31:0] data);
    bus.scr_fb_we[i]            = we;
    bus.scr_fb_addr[i*AW +: AW] = addr;
    bus.scr_fb_wdata[i*32 +: 32] = data;
  endtask

  task automatic check_reset_values();
    check("rst_we",     32'(bus.fb_we),         32'(0));
    check("rst_addr",   32'(bus.fb_addr),       32'(0));
    check("rst_wdata",  bus.fb_wdata,           32'(0));
    check("rst_scrrst", 32'(bus.scr_rst_n),     32'(0));
    check("rst_active", 32'(bus.active_screen), 32'(0));
  endtask

  // 16 clear writes (active ID held), then the SETTLE result. A done burst
  // with a flipped game_won is injected before clear write 'inject'.
  task automatic sweep(input logic [1:0] old_s, input logic [1:0] new_s,
                       input int inject);
    for (int i = 0; i < FBP; i++) begin
      if (i == inject) begin
        bus.scr_done = 4'b1111;
        bus.game_won = ~bus.game_won;
      end
      step();
      bus.scr_done = 4'b0000;
      check("clr_we",     32'(bus.fb_we),         32'(1));
      check("clr_addr",   32'(bus.fb_addr),       32'(i));
      check("clr_wdata",  bus.fb_wdata,           32'(0));
      check("clr_scrrst", 32'(bus.scr_rst_n),     32'(0));
      check("clr_active", 32'(bus.active_screen), 32'(old_s));
    end
    step();
    check("settle_we",     32'(bus.fb_we),         32'(0));
    check("settle_scrrst", 32'(bus.scr_rst_n),     32'(4'b0001 << new_s));
    check("settle_active", 32'(bus.active_screen), 32'(new_s));
  endtask

  // Done cycle followed by the dead cycle.
  task automatic do_done(input logic [3:0] done, input logic won,
                         input logic [1:0] cur);
    bus.scr_done = done;
    bus.game_won = won;
    step();
    bus.scr_done = 4'b0000;
    check("dead_we",     32'(bus.fb_we),         32'(0));
    check("dead_scrrst", 32'(bus.scr_rst_n),     32'(0));
    check("dead_active", 32'(bus.active_screen), 32'(cur));
  endtask

  initial begin
    bus.scr_fb_we    = '0;
    bus.scr_fb_addr  = '0;
    bus.scr_fb_wdata = '0;
    bus.scr_done     = '0;
    bus.game_won     = 1'b0;

    // Reset bring-up.
    step();
    step();
    check_reset_values();
    reset_n = 1'b1;
    sweep(2'd0, 2'd0, -1);

    // Forwarding on MENU; screen 1 must never reach the framebuffer.
    set_screen(0, 1'b1, 8'd5, 32'hABC);
    set_screen(1, 1'b1, 8'd9, 32'h999);
    step();
    check("fwd_we",    32'(bus.fb_we),   32'(1));
    check("fwd_addr",  32'(bus.fb_addr), 32'(5));
    check("fwd_wdata", bus.fb_wdata,     32'hABC);
    set_screen(0, 1'b0, 8'd6, 32'h123);
    step();
    check("fwd_idle_we", 32'(bus.fb_we),   32'(0));
    check("fwd_idle_a",  32'(bus.fb_addr), 32'(6));
    set_screen(1, 1'b0, 8'd0, 32'h0);

    // Dropped write on MENU done, then GAME.
    set_screen(0, 1'b1, 8'd3, 32'h55);
    do_done(4'b0001, 1'b0, 2'd0);
    set_screen(0, 1'b0, 8'd0, 32'h0);
    sweep(2'd0, 2'd1, -1);

    // Non-active done bits ignored in GAME while forwarding continues.
    set_screen(1, 1'b1, 8'd2, 32'h77);
    bus.scr_done = 4'b1101;
    step();
    bus.scr_done = 4'b0000;
    check("ign_we",     32'(bus.fb_we),         32'(1));
    check("ign_addr",   32'(bus.fb_addr),       32'(2));
    check("ign_wdata",  bus.fb_wdata,           32'h77);
    check("ign_scrrst", 32'(bus.scr_rst_n),     32'(4'b0010));
    check("ign_active", 32'(bus.active_screen), 32'(1));
    set_screen(1, 1'b0, 8'd0, 32'h0);
    step();
    check("ign_idle_we", 32'(bus.fb_we), 32'(0));

    // GAME won -> WIN, with a done burst mid-clear that must not retarget.
    do_done(4'b0010, 1'b1, 2'd1);
    sweep(2'd1, 2'd2, 5);

    // WIN -> MENU -> GAME, GAME lost -> LOSE, LOSE -> MENU.
    do_done(4'b0100, 1'b0, 2'd2);
    sweep(2'd2, 2'd0, -1);
    do_done(4'b0001, 1'b0, 2'd0);
    sweep(2'd0, 2'd1, -1);
    do_done(4'b0010, 1'b0, 2'd1);
    sweep(2'd1, 2'd3, -1);
    do_done(4'b1000, 1'b1, 2'd3);
    sweep(2'd3, 2'd0, 9);

    // Reset in the middle of the MENU -> GAME clear.
    do_done(4'b0001, 1'b0, 2'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      check("mid_addr", 32'(bus.fb_addr), 32'(i));
    end
    reset_n = 1'b0;
    #1;
    check_reset_values();
    step();
    step();
    check_reset_values();
    reset_n = 1'b1;
    sweep(2'd0, 2'd0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/screen_sequencer.md
# screen_sequencer

Top-level screen controller for the console: owns the single framebuffer write port and shares it among the four full-screen modules (menu, game, win, lose). Sequences MENU → GAME → WIN/LOSE → MENU on each screen's `screen_done` pulse. Zero-fills the framebuffer between screens. Holds inactive screens in reset so each one re-arms its key-edge logic on entry.

## Interface
Parameters:
- `FB_PIXELS`, 76800: framebuffer words cleared per transition (320×240); the bench overrides it with a small value.
- `ADDR_W`, `` `DISP_ADDR_WIDTH ``: framebuffer address width.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `scr_fb_we`  in  4  per-screen write enable; bit i belongs to screen i.
- `scr_fb_addr`  in  4×ADDR_W  packed per-screen address; screen i occupies slice [i*ADDR_W +: ADDR_W].
- `scr_fb_wdata`  in  4×32  packed per-screen write data; screen i occupies slice [i*32 +: 32].
- `scr_done`  in  4  per-screen `screen_done`; may be combinational single-cycle pulses.
- `game_won`  in  1  game outcome level; sampled in the cycle GAME asserts done.
- `scr_rst_n`  out  4  per-screen active-low reset; only the active screen's bit may be high.
- `active_screen`  out  2  current screen ID: 0 MENU, 1 GAME, 2 WIN, 3 LOSE.
- `fb_we`  out  1  framebuffer write enable (registered).
- `fb_addr`  out  ADDR_W  framebuffer address (registered).
- `fb_wdata`  out  32  framebuffer write data (registered).

## Operation
- FSM states: CLEAR, SETTLE, RUN. Registered `target` holds the screen ID that becomes active.
- **CLEAR**
  - `clr_cnt` counts 0..FB_PIXELS-1, one write per cycle.
  - Each cycle drives `fb_we`=1, `fb_addr`=clr_cnt, `fb_wdata`=0.
  - After the FB_PIXELS-1 write: `clr_cnt` returns to 0 and the FSM goes to SETTLE.
  - All `scr_rst_n` bits are 0 throughout.
- **SETTLE** (exactly 1 cycle)
  - `fb_we`=0.
  - `scr_rst_n[target]` goes 1 on entry; the other bits stay 0.
  - `active_screen`=target.
  - Next state is RUN.
- **RUN**
  - Each cycle, the active screen's `we`/`addr`/`wdata` are registered to `fb_*`.
  - Inputs from the other screens are ignored.
- **Transition** when `scr_done[active_screen]`=1 in RUN:
  - `next` is computed as: MENU→GAME; GAME→(`game_won` ? WIN : LOSE); WIN→MENU; LOSE→MENU.
  - `target` is set to `next`.
  - All `scr_rst_n` bits go 0 on the next edge.
  - The FSM goes to CLEAR.
  - The write presented in the done cycle is dropped: `fb_we`=0 in the following cycle, and CLEAR writes start the cycle after that.
- Boundary rules:
  - `scr_done` from a non-active screen: ignored in every state.
  - `scr_done` during CLEAR or SETTLE: ignored.
  - Several `scr_done` bits asserted together: only the active bit counts.
- Reset (async, at any point, including mid-CLEAR):
  - state=CLEAR, `target`=MENU, `clr_cnt`=0.
  - `active_screen`=0.
  - `fb_we`=0, `fb_addr`=0, `fb_wdata`=0.
  - `scr_rst_n`=4'b0000.
  - No partial clear is resumed; clearing restarts at address 0.

## Timing
- Reset release at edge 0:
  - First clear write (addr 0) is visible after edge 1.
  - Last write (addr FB_PIXELS-1) is visible after edge FB_PIXELS.
  - SETTLE (`fb_we`=0, `scr_rst_n`=0001) after edge FB_PIXELS+1.
  - RUN forwarding begins at the next edge.
- RUN forwarding latency: exactly 1 cycle (inputs at cycle t appear on `fb_*` at cycle t+1).
- Transition cost: done cycle, then 1 dead cycle, then FB_PIXELS clear cycles, then 1 SETTLE cycle. Total dead time on screen inputs: FB_PIXELS+2 cycles.
- `active_screen` changes only on SETTLE entry; it holds the old ID through CLEAR.
- `clr_cnt` is 17 bits for the default; width is $clog2(FB_PIXELS). Compare with == FB_PIXELS-1; never rely on natural overflow.

## Structure
- Shared package `screen_pkg`:
  - screen ID constants SCR_MENU=0, SCR_GAME=1, SCR_WIN=2, SCR_LOSE=3;
  - state encodings;
  - default FB_PIXELS.
- One sub-module `fb_clear_counter`:
  - inputs `start`; outputs `addr`, `busy`, `last`;
  - owns `clr_cnt` and wraps to 0 after `last`.
- The sequencer owns the FSM, the next-screen function, the output mux and `scr_rst_n` decode.

## Test plan
- Use FB_PIXELS=16 for all scenarios.
- **Reset bring-up:** release reset → `fb_we`=1 with addr 0..15 and wdata=0 on 16 consecutive cycles → one cycle `fb_we`=0 → `scr_rst_n`=0001, `active_screen`=0.
- **Forwarding:** in RUN on MENU, drive screen 0 we=1, addr=5, wdata=0xABC, and screen 1 we=1, addr=9 → next cycle `fb_addr`=5, `fb_wdata`=0xABC; screen 1 never appears.
- **Outcome routing:**
  - MENU done → 16 clears → `active_screen`=1, `scr_rst_n`=0010.
  - GAME done with `game_won`=1 → active 2.
  - Repeat with `game_won`=0 → active 3.
  - WIN/LOSE done → active 0.
- **Ignored done:** in RUN on GAME, pulse `scr_done`=4'b1101 → no transition. Pulse `scr_done` during CLEAR → clear completes unchanged, `target` unchanged.
- **Dropped write on done:** screen 0 asserts we=1 together with done → following cycle `fb_we`=0; the next cycle is clear write addr 0.
- **Reset mid-CLEAR:** assert `reset_n`=0 at clear addr 7 → outputs go immediately to reset values. On release, clearing restarts at addr 0 and ends in MENU.
